// File: rtl/i2c_edid_slave_if.sv
// DDC/EDID slave bus bundle: I2C pad lines plus the synchronous EDID ROM port.
interface i2c_edid_slave_if #(
  parameter int unsigned SEG_W = 1
);
  logic               scl_i;
  logic               sda_i;
  logic               sda_oe;
  logic [8+SEG_W-1:0] rom_addr;
  logic [7:0]         rom_data;
  logic               busy;
  logic               rd_byte_stb;

  modport slave  (input  scl_i, sda_i, rom_data,
                  output sda_oe, rom_addr, busy, rd_byte_stb);
  modport master (output scl_i, sda_i, rom_data,
                  input  sda_oe, rom_addr, busy, rd_byte_stb);
endinterface

// File: rtl/i2c_edid_slave.sv
// DDC/EDID I2C slave serving random, current-address and sequential reads from a sync ROM.
// Define EDDC_SEGMENT_EN to accept E-DDC segment-pointer writes at SEG_ADDR.
module i2c_edid_slave #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter logic [6:0]  SEG_ADDR = 7'h30,
  parameter int unsigned SEG_W    = 1,
  parameter int unsigned FILT_LEN = 4
) (
  input logic             clk,
  input logic             rst,
  i2c_edid_slave_if.slave bus
);
  localparam int unsigned CW = $clog2(FILT_LEN);
`ifdef EDDC_SEGMENT_EN
  localparam bit SEG_EN = 1'b1;
`else
  localparam bit SEG_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WORD, WORD_ACK, TX, TX_ACK, WAIT} state_t;

  // Index 0 = SCL, index 1 = SDA; idle bus level is high.
  logic [1:0]    sync1_q, sync2_q, filt_q;
  logic [CW-1:0] cnt_q [2];
  logic [1:0]    flip_c, rise_c, fall_c;

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      flip_c[i] = (sync2_q[i] != filt_q[i]) && (cnt_q[i] == CW'(FILT_LEN - 1));
      rise_c[i] = flip_c[i] & sync2_q[i];
      fall_c[i] = flip_c[i] & ~sync2_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      filt_q   <= '1;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q <= {bus.sda_i, bus.scl_i};
      sync2_q <= sync1_q;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i] || flip_c[i]) cnt_q[i] <= '0;
        else                                      cnt_q[i] <= cnt_q[i] + CW'(1);
        if (flip_c[i]) filt_q[i] <= sync2_q[i];
      end
    end
  end

  logic scl_r, scl_f, sda_s, start_c, stop_c;
  assign scl_r   = rise_c[0];
  assign scl_f   = fall_c[0];
  assign sda_s   = filt_q[1];
  assign start_c = fall_c[1] & filt_q[0];
  assign stop_c  = rise_c[1] & filt_q[0];

  state_t           state_q, state_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d, offset_q, offset_d;
  logic [SEG_W-1:0] segment_q, segment_d;
  logic             oe_q, oe_d, busy_q, busy_d, stb_q, stb_d;
  logic             rw_q, rw_d, tgt_seg_q, tgt_seg_d, first_q, first_d, ack_q, ack_d;

  logic [7:0] byte_c;
  logic       match_dev, match_seg;
  assign byte_c    = {shift_q[6:0], sda_s};
  assign match_dev = (byte_c[7:1] == DEV_ADDR);
  assign match_seg = SEG_EN && (byte_c[7:1] == SEG_ADDR) && !byte_c[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      offset_q  <= '0;
      segment_q <= '0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      stb_q     <= 1'b0;
      rw_q      <= 1'b0;
      tgt_seg_q <= 1'b0;
      first_q   <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      offset_q  <= offset_d;
      segment_q <= segment_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      stb_q     <= stb_d;
      rw_q      <= rw_d;
      tgt_seg_q <= tgt_seg_d;
      first_q   <= first_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    offset_d  = offset_q;
    segment_d = segment_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    stb_d     = 1'b0;
    rw_d      = rw_q;
    tgt_seg_d = tgt_seg_q;
    first_d   = first_q;
    ack_d     = ack_q;
    if (stop_c) begin
      state_d   = IDLE;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
      segment_d = '0;
    end else if (start_c) begin
      state_d  = ADDR;
      oe_d     = 1'b0;
      busy_d   = 1'b1;
      bitcnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE, WAIT: ;
        ADDR, WORD: if (scl_r) begin
          shift_d  = byte_c;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            if (state_q == WORD) begin
              state_d = WORD_ACK;
              first_d = 1'b0;
              if (first_q) begin
                if (tgt_seg_q) segment_d = byte_c[SEG_W-1:0];
                else           offset_d  = byte_c;
              end
            end else if (match_dev || match_seg) begin
              state_d   = ADDR_ACK;
              rw_d      = byte_c[0];
              tgt_seg_d = match_seg;
            end else begin
              state_d = WAIT;
              busy_d  = 1'b0;
            end
          end
        end
        // First scl_f starts the ACK, the second ends it; the first read bit goes out on that same edge.
        ADDR_ACK, WORD_ACK: if (scl_f) begin
          if (!oe_q) begin
            oe_d = 1'b1;
          end else if (state_q == ADDR_ACK && rw_q) begin
            state_d  = TX;
            shift_d  = {bus.rom_data[6:0], 1'b0};
            oe_d     = ~bus.rom_data[7];
            bitcnt_d = 3'd1;
          end else begin
            state_d  = WORD;
            oe_d     = 1'b0;
            bitcnt_d = '0;
            if (state_q == ADDR_ACK) first_d = 1'b1;
          end
        end
        TX: if (scl_f) begin
          if (bitcnt_q == 3'd0) begin
            state_d  = TX_ACK;
            oe_d     = 1'b0;
            offset_d = offset_q + 8'd1;
            stb_d    = 1'b1;
            ack_d    = 1'b0;
          end else begin
            oe_d     = ~shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
        TX_ACK: begin
          if (scl_r) begin
            if (sda_s) state_d = WAIT;
            else       ack_d   = 1'b1;
          end else if (scl_f && ack_q) begin
            state_d  = TX;
            shift_d  = {bus.rom_data[6:0], 1'b0};
            oe_d     = ~bus.rom_data[7];
            bitcnt_d = 3'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    bus.sda_oe      = oe_q;
    bus.busy        = busy_q;
    bus.rd_byte_stb = stb_q;
    bus.rom_addr    = {segment_q, offset_q};
  end
endmodule

// File: tb/tb_i2c_edid_slave.sv
// Bench for i2c_edid_slave: bit-banged I2C master, ROM model, scoreboard on rd_byte_stb.
`timescale 1ns/1ps
module tb_i2c_edid_slave;
  localparam int unsigned SEG_W = 1;
  localparam int unsigned AW    = 8 + SEG_W;
  localparam int          Q     = 12;

  logic clk = 1'b0;
  logic rst;
  logic scl_m, sda_m;
  logic [7:0] rom_mem [2**AW];

  i2c_edid_slave_if #(.SEG_W(SEG_W)) bus_if ();

  i2c_edid_slave #(
    .DEV_ADDR(7'h50),
    .SEG_ADDR(7'h30),
    .SEG_W   (SEG_W),
    .FILT_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  assign bus_if.scl_i = scl_m;
  assign bus_if.sda_i = sda_m & ~bus_if.sda_oe;
  always_ff @(posedge clk) bus_if.rom_data <= rom_mem[bus_if.rom_addr];

  typedef struct packed {
    logic [7:0]    data;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t             exp_q[$];
  int               tests = 0;
  int               fails = 0;
  logic [7:0]       sniff = '0;
  logic [7:0]       off_m;
  logic [SEG_W-1:0] seg_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Byte seen on the wire, sampled where the master samples: rising SCL.
  always @(posedge scl_m) sniff <= {sniff[6:0], bus_if.sda_i};

  initial begin
    forever begin
      @(negedge clk);
      if (bus_if.rd_byte_stb === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_stb: actual stb with empty queue, required none (sniff %0h)", sniff);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rd_data", sniff, e.data);
          check("rd_addr", bus_if.rom_addr, e.addr);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; wclk(Q);
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b1; wclk(2*Q);
`ifdef EDDC_SEGMENT_EN
    seg_m = '0;
`endif
  endtask

  task automatic write_byte(input logic [7:0] b, input bit glitch, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wclk(Q);
      scl_m = 1'b1;
      if (glitch && i == 4) begin
        wclk(8); scl_m = 1'b0; wclk(2); scl_m = 1'b1; wclk(2*Q - 10);
      end else begin
        wclk(2*Q);
      end
      scl_m = 1'b0; wclk(Q/2);
    end
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    ack = bus_if.sda_i;
    wclk(Q);
    scl_m = 1'b0; wclk(Q/2);
  endtask

  task automatic read_byte(input bit master_ack);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wclk(Q); scl_m = 1'b1; wclk(2*Q); scl_m = 1'b0;
    end
    wclk(Q/2); sda_m = master_ack ? 1'b0 : 1'b1; wclk(Q/2);
    scl_m = 1'b1; wclk(2*Q);
    scl_m = 1'b0; wclk(Q/2);
    sda_m = 1'b1; wclk(Q/2);
  endtask

  task automatic send(input logic [7:0] b, input bit exp_ack, input string name, input bit glitch = 1'b0);
    logic a;
    write_byte(b, glitch, a);
    check(name, a, {31'd0, ~exp_ack});
  endtask

  task automatic read_n(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.data = rom_mem[{seg_m, off_m}];
      e.addr = {seg_m, 8'(off_m + 8'd1)};
      exp_q.push_back(e);
      off_m = off_m + 8'd1;
      read_byte(k != n - 1);
    end
  endtask

  task automatic random_read(input logic [7:0] off, input int n);
    i2c_start();
    send(8'hA0, 1'b1, "rr_dev_w");
    send(off, 1'b1, "rr_word");
    off_m = off;
    i2c_rstart();
    send(8'hA1, 1'b1, "rr_dev_r");
    read_n(n);
    i2c_stop();
  endtask

  task automatic current_read(input int n);
    i2c_start();
    send(8'hA1, 1'b1, "cr_dev_r");
    read_n(n);
    i2c_stop();
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 2**AW; i++) rom_mem[i] = 8'($urandom);
    rom_mem[9'h040] = 8'h3C;
    scl_m = 1'b1; sda_m = 1'b1; rst = 1'b1;
    off_m = '0; seg_m = '0;
    wclk(5);
    @(negedge clk);
    check("rst_sda_oe", bus_if.sda_oe, 0);
    check("rst_rom_addr", bus_if.rom_addr, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_stb", bus_if.rd_byte_stb, 0);
    rst = 1'b0;
    wclk(10);

    // Random read of three bytes from 0x10
    i2c_start();
    check("busy_after_start", bus_if.busy, 1);
    send(8'hA0, 1'b1, "t1_dev_w");
    send(8'h10, 1'b1, "t1_word");
    off_m = 8'h10;
    i2c_rstart();
    send(8'hA1, 1'b1, "t1_dev_r");
    read_n(3);
    i2c_stop();
    check("t1_busy_after_stop", bus_if.busy, 0);
    check("t1_rom_addr", bus_if.rom_addr, {seg_m, off_m});
    check("t1_drain", exp_q.size(), 0);

    // Foreign address is ignored, then a current-address read continues
    i2c_start();
    send(8'hA2, 1'b0, "t2_foreign_nack");
    check("t2_busy_released", bus_if.busy, 0);
    i2c_stop();
    current_read(2);

    // Offset wrap and discarded extra write bytes
    random_read(8'hFE, 3);
    check("t3_upper_bits", bus_if.rom_addr[AW-1:8], seg_m);
    i2c_start();
    send(8'hA0, 1'b1, "t3_dev_w");
    send(8'h20, 1'b1, "t3_word");
    send(8'h55, 1'b1, "t3_extra_ack");
    i2c_stop();
    off_m = 8'h20;
    current_read(1);

    // Short glitches on an idle bus and inside an address bit
    scl_m = 1'b0; wclk(2); scl_m = 1'b1; wclk(20);
    sda_m = 1'b0; wclk(2); sda_m = 1'b1; wclk(20);
    check("t4_no_start", bus_if.busy, 0);
    i2c_start();
    send(8'hA1, 1'b1, "t4_glitch_addr", 1'b1);
    read_n(2);
    i2c_stop();

    // Reset while the slave is pulling SDA low in a read
    i2c_start();
    send(8'hA0, 1'b1, "t4r_dev_w");
    send(8'h40, 1'b1, "t4r_word");
    i2c_rstart();
    send(8'hA1, 1'b1, "t4r_dev_r");
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (bus_if.sda_oe === 1'b1) seen = 1'b1;
    end
    check("t4r_driving_low", seen, 1);
    #2 rst = 1'b1;
    #1;
    check("t4r_async_release", bus_if.sda_oe, 0);
    check("t4r_busy", bus_if.busy, 0);
    wclk(3);
    rst = 1'b0;
    off_m = '0; seg_m = '0;
    wclk(5);
    i2c_stop();
    current_read(2);

`ifdef EDDC_SEGMENT_EN
    i2c_start();
    send(8'h60, 1'b1, "t5_seg_addr");
    send(8'h01, 1'b1, "t5_seg_val");
    seg_m = 1'b1;
    i2c_rstart();
    send(8'hA0, 1'b1, "t5_dev_w");
    send(8'h00, 1'b1, "t5_word");
    off_m = 8'h00;
    i2c_rstart();
    send(8'hA1, 1'b1, "t5_dev_r");
    read_n(1);
    i2c_stop();
    random_read(8'h00, 1);
    i2c_start();
    send(8'h61, 1'b0, "t5_seg_read_nack");
    i2c_stop();
`else
    i2c_start();
    send(8'h60, 1'b0, "t6_seg_nack");
    check("t6_busy", bus_if.busy, 0);
    i2c_stop();
    check("t6_seg_bit", bus_if.rom_addr[8], 0);
`endif

    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 1) == 1) random_read(8'($urandom_range(0, 255)), $urandom_range(1, 4));
      else                           current_read($urandom_range(1, 4));
      check("rand_rom_addr", bus_if.rom_addr, {seg_m, off_m});
    end

    wclk(20);
    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
